// File: rtl/inst_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
// A request holds req/addr steady until the memory answers with ack and rdata.
interface inst_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetches one word, holds it until retired, then steers PC.
// Define IF_TIMEOUT_EN to build the fetch wait counter and sticky ERR state.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_if.master       imem,
  output logic [31:0]        inst,
  output logic [5:0]         inst_31_26,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               branch,
  input  logic               branch_not_equal,
  input  logic               jump,
  input  logic               zero,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc_plus4,
  output logic               fetch_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("inst_fetch: TIMEOUT must be at least 1");
  end

`ifdef IF_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        take_branch;

`ifdef IF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  // The last unacknowledged cycle is the TIMEOUT-th one spent in FETCH.
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
`endif

  // Branch/jump controls belong to the held instruction, so next_pc is only
  // consumed on the HOLD cycle that retires it.
  assign branch_off  = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign take_branch = (branch & zero) | (branch_not_equal & ~zero);

  always_comb begin
    if (jump)             next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
    else if (take_branch) next_pc = pc_plus4 + branch_off;
    else                  next_pc = pc_plus4;
  end

  always_comb begin
    // NOTE: assign the default before the case so no path leaves state_next unassigned (latch).
    state_next = state;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (imem.ack)       state_next = HOLD;
`ifdef IF_TIMEOUT_EN
        else if (timed_out) state_next = ERR;
`endif
      end
      HOLD:    if (inst_ready) state_next = FETCH;
      default: state_next = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      if (state == FETCH && imem.ack) begin
        inst       <= imem.rdata;
        inst_valid <= 1'b1;
      end
      if (state == HOLD && inst_ready) begin
        pc         <= next_pc;
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef IF_TIMEOUT_EN
  // Held at zero outside FETCH, so every new request starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (state != FETCH)  wait_cnt <= '0;
    else if (!imem.ack)       wait_cnt <= wait_cnt + 1'b1;
  end

  assign fetch_err = (state == ERR);
`else
  assign fetch_err = 1'b0;
`endif

  // Request is decoded from state, so an asynchronous reset drops it at once.
  assign imem.req   = (state == FETCH);
  assign imem.addr  = pc;
  assign pc_out     = pc;
  assign pc_plus4   = pc + 32'd4;
  assign inst_31_26 = inst[31:26];

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus pushes expected (pc, word) pairs, a
// monitor pops and compares each time Inst_Valid rises.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic [5:0]  inst_31_26;
  logic        inst_valid;
  logic        inst_ready;
  logic        branch, branch_not_equal, jump, zero;
  logic [31:0] pc_out, pc_plus4;
  logic        fetch_err;

  localparam logic [31:0] ADDI = 32'h2008_0005;
  localparam logic [31:0] BNE  = 32'h1509_0003;
  localparam logic [31:0] BEQ_BACK1 = 32'h1000_FFFF;
  localparam logic [31:0] BEQ_WRAP  = 32'h1000_FEFC;

  always #5 clk = ~clk;

  inst_fetch_if imem ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem),
    .inst             (inst),
    .inst_31_26       (inst_31_26),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .branch           (branch),
    .branch_not_equal (branch_not_equal),
    .jump             (jump),
    .zero             (zero),
    .pc_out           (pc_out),
    .pc_plus4         (pc_plus4),
    .fetch_err        (fetch_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every newly valid instruction must match the oldest expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (inst_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_inst: got pc %h inst %h with nothing expected", pc_out, inst);
      end else begin : pop_cmp
        exp_t e;
        e = sb.pop_front();
        check("mon_pc_out", pc_out, e.pc);
        check("mon_inst", inst, e.word);
        check("mon_opcode", {26'd0, inst_31_26}, {26'd0, e.word[31:26]});
      end
    end
    prev_valid = inst_valid;
  end

  // Serve one fetch at exp_pc with word, optionally stall in HOLD (last stall
  // cycle carries a spurious ack), then retire with the given control inputs.
  task automatic serve(input logic [31:0] exp_pc, input logic [31:0] word,
                       input logic br, input logic bne, input logic jmp, input logic z,
                       input int stall, input bit immediate);
    int n = 0;
    while (!imem.req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem.req) begin
      check("req_wait", {31'd0, imem.req}, 32'd1);
      return;
    end
    if (immediate) check("req_back_to_back", n, 0);
    check("fetch_addr", imem.addr, exp_pc);
    sb.push_back('{exp_pc, word});
    imem.ack   = 1'b1;
    imem.rdata = word;
    @(negedge clk);
    imem.ack   = 1'b0;
    imem.rdata = 32'hDEAD_BEEF;
    check("hold_req", {31'd0, imem.req}, 32'd0);
    check("hold_pc_plus4", pc_plus4, exp_pc + 32'd4);
    for (int i = 0; i < stall; i++) begin
      imem.ack = (i == stall - 1);
      @(negedge clk);
      check("stall_req", {31'd0, imem.req}, 32'd0);
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_inst", inst, word);
      check("stall_pc_out", pc_out, exp_pc);
    end
    imem.ack         = 1'b0;
    branch           = br;
    branch_not_equal = bne;
    jump             = jmp;
    zero             = z;
    inst_ready       = 1'b1;
    @(negedge clk);
    inst_ready       = 1'b0;
    branch           = 1'b0;
    branch_not_equal = 1'b0;
    jump             = 1'b0;
    zero             = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    imem.ack         = 1'b0;
    imem.rdata       = 32'h0;
    inst_ready       = 1'b0;
    branch           = 1'b0;
    branch_not_equal = 1'b0;
    jump             = 1'b0;
    zero             = 1'b0;

    #3;
    check("rst_req", {31'd0, imem.req}, 32'd0);
    check("rst_addr", imem.addr, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_opcode", {26'd0, inst_31_26}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_err", {31'd0, fetch_err}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Sequential addi stream at 2-cycle spacing.
    serve(32'h0000_0000, ADDI, 0, 0, 0, 0, 0, 0);
    serve(32'h0000_0004, ADDI, 0, 0, 0, 0, 0, 1);
    serve(32'h0000_0008, ADDI, 0, 0, 0, 0, 0, 1);
    serve(32'h0000_000C, ADDI, 0, 0, 0, 0, 0, 1);
    // bne taken, jump back, bne not taken, jump wins over a taken branch.
    serve(32'h0000_0010, BNE,          0, 1, 0, 0, 0, 1);
    serve(32'h0000_0020, 32'h0C00_0004, 0, 0, 1, 0, 0, 1);
    serve(32'h0000_0010, BNE,          0, 1, 0, 1, 0, 1);
    serve(32'h0000_0014, 32'h0C00_0010, 1, 0, 1, 1, 0, 1);
    // jal at 0x40 to 0x400.
    serve(32'h0000_0040, 32'h0C00_0100, 0, 0, 1, 0, 0, 1);
    // Stall 5 cycles then a spurious ack in HOLD.
    serve(32'h0000_0400, ADDI, 0, 0, 0, 0, 6, 1);
    // Negative offset branch back onto itself, then beq not taken.
    serve(32'h0000_0404, BEQ_BACK1, 1, 0, 0, 1, 0, 1);
    serve(32'h0000_0404, BEQ_WRAP,  1, 0, 0, 0, 0, 1);
    // Backward branch below zero wraps to the top of the address space.
    serve(32'h0000_0408, BEQ_WRAP,  1, 0, 0, 1, 0, 1);
    serve(32'hFFFF_FFFC, ADDI, 0, 0, 0, 0, 0, 1);
    serve(32'h0000_0000, ADDI, 0, 0, 0, 0, 0, 1);

    // Reset while FETCH at 0x4 has an ack about to land.
    imem.ack   = 1'b1;
    imem.rdata = 32'h1234_5678;
    #2 rst_n = 1'b0;
    #1;
    check("rst_fetch_req", {31'd0, imem.req}, 32'd0);
    check("rst_fetch_addr", imem.addr, 32'h0);
    @(negedge clk);
    check("rst_fetch_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fetch_inst", inst, 32'h0);
    imem.ack = 1'b0;
    rst_n    = 1'b1;
    serve(32'h0000_0000, ADDI, 0, 0, 0, 0, 0, 0);

    // Ack withheld in FETCH at 0x4.
    imem.ack = 1'b0;
`ifdef IF_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("to_req_pending", {31'd0, imem.req}, 32'd1);
      check("to_err_clear", {31'd0, fetch_err}, 32'd0);
    end
    @(negedge clk);
    check("to_err_set", {31'd0, fetch_err}, 32'd1);
    check("to_req_drop", {31'd0, imem.req}, 32'd0);
    imem.ack   = 1'b1;
    inst_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("err_sticky", {31'd0, fetch_err}, 32'd1);
      check("err_req", {31'd0, imem.req}, 32'd0);
      check("err_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem.ack   = 1'b0;
    inst_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("err_rst_clear", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    serve(32'h0000_0000, ADDI, 0, 0, 0, 0, 0, 0);
`else
    repeat (20) begin
      @(negedge clk);
      check("wait_req", {31'd0, imem.req}, 32'd1);
      check("wait_no_err", {31'd0, fetch_err}, 32'd0);
    end
    serve(32'h0000_0004, ADDI, 0, 0, 0, 0, 0, 1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
